// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM state encoding, default RAM geometry and byte-lane select values for the load/store unit
package lsu_pkg;
  localparam int LSU_WADDR_W = 10;
  localparam int LSU_DATA_W = 16;
  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
endpackage

// File: rtl/lsu_if.sv
// lsu_if: CPU-side request/response handshake (master = CPU memory stage, slave = lsu)
interface lsu_if #(
  parameter int WADDR_W = lsu_pkg::LSU_WADDR_W,
  parameter int DATA_W = lsu_pkg::LSU_DATA_W
);
  logic req_valid, req_ready, req_we, req_byte, req_signed;
  logic [WADDR_W:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  modport master(
    output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave(
    input req_valid, req_we, req_byte, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: word_i/lane_i/sgn_i/byte_i in; ext_o = selected lane sign/zero extended, mrg_o = word_i with lane replaced by byte_i
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [15:0] word_i,
  input  logic        lane_i,
  input  logic        sgn_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] ext_o,
  output logic [15:0] mrg_o
);
  logic [7:0] b;
  always_comb begin
    b = lane_i == LANE_HI ? word_i[15:8] : word_i[7:0];
    ext_o = {{8{sgn_i & b[7]}}, b};
    mrg_o = lane_i == LANE_LO ? {word_i[15:8], byte_i} : {byte_i, word_i[7:0]};
  end
endmodule

// File: rtl/lsu.sv
// lsu: byte/word load-store FSM in front of a word RAM; ports clk, rst_n, bus (lsu_if.slave), ram_write_n/ram_addr/ram_wdata out, ram_rdata in; ACCESS spends one cycle presenting the address and samples the RAM in its second cycle
module lsu
  import lsu_pkg::*;
#(
  parameter int WADDR_W = LSU_WADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  lsu_if.slave               bus,
  output logic               ram_write_n,
  output logic [WADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata
);
  state_t state_q, state_d;
  logic settle_q, we_q, byte_q, sgn_q, lane_q, err_q, mis;
  logic [WADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, wd_q, ext, mrg, wd;
  lsu_byte_lane u_lane (
    .word_i(ram_rdata),
    .lane_i(lane_q),
    .sgn_i(sgn_q),
    .byte_i(wdata_q[7:0]),
    .ext_o(ext),
    .mrg_o(mrg)
  );
  assign mis = !byte_q && lane_q;
  assign wd = byte_q ? mrg : wdata_q;
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE   ? (bus.req_valid ? ACCESS : IDLE)
            : state_q == ACCESS ? (!settle_q ? ACCESS : (we_q && !mis) ? WRITE : RESP)
            : state_q == WRITE  ? RESP
            : bus.rsp_ready     ? IDLE : RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      settle_q <= 1'b0;
      we_q <= 1'b0;
      byte_q <= 1'b0;
      sgn_q <= 1'b0;
      lane_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wd_q <= '0;
    end else begin
      settle_q <= state_q == ACCESS && !settle_q;
      if (state_q == IDLE && bus.req_valid) begin
        we_q <= bus.req_we;
        byte_q <= bus.req_byte;
        sgn_q <= bus.req_signed;
        lane_q <= bus.req_addr[0];
        addr_q <= bus.req_addr[WADDR_W:1];
        wdata_q <= bus.req_wdata;
      end
      if (state_q == ACCESS && settle_q) begin
        err_q <= mis;
        rdata_q <= (mis || we_q) ? '0 : byte_q ? ext : ram_rdata;
        if (we_q && !mis) wd_q <= wd;
      end
    end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err = err_q;
  assign ram_write_n = state_q != WRITE;
  assign ram_addr = addr_q;
  assign ram_wdata = state_q == ACCESS ? wd : wd_q;
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly upstream of the 1024×16 word RAM: accepts byte-addressed load/store requests from the CPU memory stage over a valid/ready handshake and drives the RAM's active-low write strobe, word address and write data. It converts byte accesses into word accesses, with sign/zero extension on loads and read-modify-write on byte stores. Results return over a valid/ready response channel. One request is in flight at a time.

## Interface
- `WADDR_W`, default 10: RAM word-address width; the byte address is `WADDR_W+1` bits.
- `DATA_W`, default 16: RAM word width. Fixed at 16, i.e. two byte lanes.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_byte` in 1: 1 = byte access, 0 = 16-bit word access.
- `req_signed` in 1: byte loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 11: byte address; `[10:1]` is the word, `[0]` is the lane.
- `req_wdata` in 16: store data; byte stores use `[7:0]`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 16: load result; 0 for stores and errors.
- `rsp_err` out 1: misaligned word access.
- `ram_write_n` out 1: to RAM `write_n`; low commits on the next `clk` rising edge.
- `ram_addr` out 10: to RAM `addr`.
- `ram_wdata` out 16: to RAM `data_in`.
- `ram_rdata` in 16: from RAM `data_out`, combinational read of `ram_addr`.

## Operation
- Byte lanes are little-endian: lane 0 is `[7:0]`, lane 1 is `[15:8]`.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`: latch we/byte/signed/addr/wdata and go to ACCESS.
- ACCESS
  - `ram_addr` = latched `addr[10:1]`; `ram_write_n`=1.
  - Misaligned (word access with `addr[0]`=1): set err, `rdata`=0, go to RESP. The RAM is never written.
  - Load:
    - Word: `rdata` = `ram_rdata`.
    - Byte: `rdata` = selected lane, extended per `signed`.
    - Go to RESP.
  - Store:
    - Word: `ram_wdata` = `wdata`.
    - Byte: `ram_wdata` = `ram_rdata` with the addressed lane replaced by `wdata[7:0]`; the other lane is preserved. Capture this value into a register.
    - Go to WRITE.
- WRITE
  - `ram_write_n`=0 for exactly one cycle, with `ram_addr`/`ram_wdata` held from the captured registers.
  - Go to RESP.
- RESP
  - `rsp_valid`=1 with `rsp_rdata`/`rsp_err` stable.
  - On `rsp_ready`: go to IDLE.
- `ram_write_n` is decoded from the state register only (low iff WRITE), so it is glitch-free. `ram_addr` holds its last value outside ACCESS/WRITE.
- Word loads ignore `req_signed`.

## Timing
- Reset values (immediate on `rst_n` low): state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `ram_write_n`=1, `ram_addr`=0, `ram_wdata`=0.
- Request accepted at edge T, when `req_valid` and `req_ready` are both high.
- Load, or misaligned request: `rsp_valid` rises after edge T+2.
- Store: the RAM write commits at edge T+3; `rsp_valid` rises after edge T+3.
- Response handshake completes at the edge where `rsp_valid` and `rsp_ready` are both high. `req_ready` returns after that edge; the earliest next accept is one cycle later.
- `req_ready`=0 in every state except IDLE. The upstream holds its request; the unit does not sample it.
- Reset asserted during WRITE before the commit edge: `ram_write_n` goes high asynchronously and no write occurs. All in-flight state is discarded.
- Back-to-back store then load to the same word: the load returns the newly written data. This follows from the RAM commit at T+3 preceding the next ACCESS.

## Structure
- Package `lsu_pkg`:
  - State enum.
  - `WADDR_W`/`DATA_W` defaults.
  - Lane-select constants.
- Sub-module `lsu_byte_lane` (combinational), responsible for:
  - lane extraction with sign/zero extension for loads;
  - lane merge for byte stores.
- FSM and registers live in `lsu`.

## Test plan
- **Word store then word load:** store `0xBEEF` at byte address `0x010`, then load `0x010` → RAM word 8 = `0xBEEF`; `rsp_rdata`=`0xBEEF`; `rsp_err`=0; write strobe low for exactly 1 cycle.
- **Byte store read-modify-write:** word 8 = `0xBEEF`; byte store `0x12` at `0x011` → word 8 = `0x12EF`. Byte store `0x34` at `0x010` → word 8 = `0x1234`.
- **Byte load extension:** word 3 = `0x80F0`.
  - Signed byte load at `0x007` → `0xFF80`.
  - Unsigned byte load at `0x007` → `0x0080`.
  - Signed byte load at `0x006` → `0xFFF0`.
- **Misaligned word store:** word store `0xAAAA` at `0x005` → `rsp_err`=1, `rsp_rdata`=0, `ram_write_n` never low, word 2 unchanged.
- **Response backpressure:** hold `rsp_ready`=0 for 5 cycles after a load of `0x1234` → `rsp_valid`/`rsp_rdata` stable at `0x1234`; `req_ready`=0 throughout; a new request is accepted only after the handshake.
- **Reset during WRITE:** assert `rst_n`=0 in the WRITE cycle of a store of `0x5555` to word 0 (old value `0x0000`) → `ram_write_n`=1 immediately, word 0 stays `0x0000`, all outputs at reset values.
